// File: rtl/pipe_if_id_hazard.sv
// IF/ID pipeline register with load-use hazard detection and branch flush.
//
// Holds the fetched instruction and PC+4 for decode. When a load sitting in
// ID/EX writes a register that the instruction in ID reads, the PC and this
// register are held for one cycle and decode is told to inject a bubble into
// ID/EX. A taken branch (flush_i) squashes the fetched instruction and takes
// priority over a stall. Saturating counters track stall and flush cycles.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           asynchronous reset, active-low
//   pc_i            PC+4 from fetch
//   instr_i         instruction from instruction memory
//   flush_i         branch taken; squash the fetched instruction
//   idex_memread_i  MemRead control currently held in ID/EX
//   idex_rt_i       rt field currently held in ID/EX
//   pc_o            registered PC+4 to decode
//   instr_o         registered instruction to decode
//   valid_o         instr_o holds a live (non-squashed) instruction
//   pc_write_o      PC update enable to fetch (combinational)
//   bubble_o        force ID/EX controls to zero (combinational)
//   stall_cnt_o     saturating count of stall cycles
//   flush_cnt_o     saturating count of flush cycles
module pipe_if_id_hazard #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      instr_i,
  input  logic             flush_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      instr_o,
  output logic             valid_o,
  output logic             pc_write_o,
  output logic             bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       uses_rt;
  logic       hazard;
  logic       stall;

  // Decode the instruction currently in ID. Only R-type, beq and sw read rt
  // as a source; for other formats rt is a destination or unused.
  always_comb begin
    op      = instr_o[31:26];
    rs      = instr_o[25:21];
    rt      = instr_o[20:16];
    uses_rt = (op == 6'b000000) || (op == 6'b000100) || (op == 6'b101011);
    // Register $0 is never a real dependency.
    hazard  = valid_o && idex_memread_i && (idex_rt_i != 5'd0) &&
              ((idex_rt_i == rs) || (uses_rt && (idex_rt_i == rt)));
    // A taken branch discards the dependent instruction anyway.
    stall   = hazard && !flush_i;
  end

  assign pc_write_o = ~stall;
  assign bubble_o   = stall;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_o        <= '0;
      instr_o     <= '0;
      valid_o     <= 1'b0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else if (flush_i) begin
      pc_o    <= pc_i;
      instr_o <= '0;
      valid_o <= 1'b0;
      if (flush_cnt_o != '1) flush_cnt_o <= flush_cnt_o + 1'b1;
    end else if (stall) begin
      if (stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
    end else begin
      pc_o    <= pc_i;
      instr_o <= instr_i;
      valid_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_if_id_hazard.sv
// Self-checking bench for pipe_if_id_hazard: directed steps followed by
// random traffic, checked against a behavioural model of the IF/ID stage.
module tb_pipe_if_id_hazard;

  localparam int CNT_W = 16;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [31:0]      pc_i;
  logic [31:0]      instr_i;
  logic             flush_i;
  logic             idex_memread_i;
  logic [4:0]       idex_rt_i;
  logic [31:0]      pc_o;
  logic [31:0]      instr_o;
  logic             valid_o;
  logic             pc_write_o;
  logic             bubble_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  pipe_if_id_hazard #(.CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .instr_i(instr_i),
    .flush_i(flush_i), .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
    .pc_o(pc_o), .instr_o(instr_o), .valid_o(valid_o),
    .pc_write_o(pc_write_o), .bubble_o(bubble_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model state
  logic [31:0] m_pc, m_instr;
  bit          m_valid;
  int          m_scnt, m_fcnt;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit reads_rt(input logic [5:0] op);
    return op inside {6'd0, 6'd4, 6'd43};
  endfunction

  // Does the instruction held in ID read the register a pending load writes?
  function automatic bit m_stall();
    bit dep;
    dep = (idex_rt_i == m_instr[25:21]) ||
          (reads_rt(m_instr[31:26]) && idex_rt_i == m_instr[20:16]);
    return m_valid && idex_memread_i && idex_rt_i != 0 && dep && !flush_i;
  endfunction

  task automatic m_reset();
    m_pc = 0; m_instr = 0; m_valid = 0; m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".pc"},    pc_o,               m_pc);
    chk({tag, ".instr"}, instr_o,            m_instr);
    chk({tag, ".valid"}, {31'd0, valid_o},   {31'd0, m_valid});
    chk({tag, ".scnt"},  {16'd0, stall_cnt_o}, m_scnt);
    chk({tag, ".fcnt"},  {16'd0, flush_cnt_o}, m_fcnt);
  endtask

  // Inputs are set at posedge+1; check combinational outputs, clock, then
  // check registered outputs at posedge+1.
  task automatic cycle(input string tag, input bit do_chk);
    bit st;
    #1;
    st = m_stall();
    if (do_chk) begin
      chk({tag, ".pc_write"}, {31'd0, pc_write_o}, {31'd0, !st});
      chk({tag, ".bubble"},   {31'd0, bubble_o},   {31'd0, st});
    end
    @(posedge clk_i);
    if (flush_i) begin
      m_pc = pc_i; m_instr = 0; m_valid = 0;
      if (m_fcnt < MAXC) m_fcnt++;
    end else if (st) begin
      if (m_scnt < MAXC) m_scnt++;
    end else begin
      m_pc = pc_i; m_instr = instr_i; m_valid = 1;
    end
    #1;
    if (do_chk) chk_regs(tag);
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] ins,
                       input logic fl, input logic mr, input logic [4:0] rt);
    pc_i = pc; instr_i = ins; flush_i = fl; idex_memread_i = mr; idex_rt_i = rt;
  endtask

  initial begin
    // Reset held with random inputs
    rst_i = 1'b0;
    m_reset();
    drive($urandom, $urandom, 1'b0, 1'b1, 5'($urandom_range(1, 31)));
    repeat (2) @(posedge clk_i);
    #1;
    chk_regs("reset");
    chk("reset.pc_write", {31'd0, pc_write_o}, 32'd1);
    chk("reset.bubble",   {31'd0, bubble_o},   32'd0);

    // Release and first load
    rst_i = 1'b1;
    drive(32'h4, 32'h00221820, 1'b0, 1'b0, 5'd0);
    cycle("first_load", 1);

    // Load-use on rs of add $3,$1,$2
    drive(32'h8, 32'h20450007, 1'b0, 1'b1, 5'd1);
    cycle("loaduse", 1);
    drive(32'h8, 32'h20450007, 1'b0, 1'b0, 5'd0);
    cycle("resume", 1);

    // addi $5,$2,7 in ID: rt is a destination, so idex_rt=5 must not stall
    drive(32'hC, 32'h20450007, 1'b0, 1'b1, 5'd5);
    cycle("itype_rt", 1);
    drive(32'h10, 32'h20450007, 1'b0, 1'b1, 5'd2);
    cycle("itype_rs", 1);

    // Flush beats stall
    drive(32'h40, 32'h12345678, 1'b1, 1'b1, 5'd2);
    cycle("flush_prio", 1);

    // valid=0 nop with a $0 match
    drive(32'h44, 32'h00001820, 1'b0, 1'b1, 5'd0);
    cycle("invalid", 1);
    // add $3,$0,$0 valid, idex_rt=0
    drive(32'h48, 32'h00001820, 1'b0, 1'b1, 5'd0);
    cycle("reg0", 1);

    // Saturate stall counter
    drive(32'h4C, 32'h00221820, 1'b0, 1'b0, 5'd0);
    cycle("pre_sat", 1);
    drive(32'h50, 32'h00221820, 1'b0, 1'b1, 5'd1);
    while (m_scnt < MAXC) cycle("sat_run", 0);
    chk_regs("sat_reached");
    cycle("sat_hold", 1);

    // Async reset pulse between edges
    #2 rst_i = 1'b0;
    m_reset();
    #1;
    chk_regs("async_rst");
    #1 rst_i = 1'b1;
    drive(32'h100, 32'h00221820, 1'b0, 1'b0, 5'd0);
    cycle("post_rst", 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [5:0]  op;
      logic [31:0] ins;
      case ($urandom_range(0, 4))
        0: op = 6'd0;
        1: op = 6'd4;
        2: op = 6'd43;
        3: op = 6'd35;
        default: op = 6'd8;
      endcase
      ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      drive($urandom, ins, ($urandom_range(0, 7) == 0), 1'($urandom),
            5'($urandom_range(0, 3)));
      cycle("rand", 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/pipe_if_id_hazard.md
Name: pipe_if_id_hazard

Overview:
IF/ID pipeline register with integrated load-use hazard detection and branch flush. It sits between instruction fetch and decode, directly upstream of the ID/EX register. It holds the fetched instruction and PC+4 for the decode stage. It stalls the PC and itself for one cycle when a load in EX feeds the instruction in ID, and it tells decode to inject a bubble into ID/EX. Saturating counters record stall and flush events for performance debug.

Parameters:
CNT_W, 16, width of the stall_cnt_o and flush_cnt_o performance counters

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-low
pc_i  input  32  PC+4 from fetch
instr_i  input  32  instruction from instruction memory
flush_i  input  1  branch taken (resolved downstream); squash the fetched instruction
idex_memread_i  input  1  MemRead control currently held in ID/EX
idex_rt_i  input  5  rt field (instr[20:16]) currently held in ID/EX
pc_o  output  32  registered PC+4 to decode
instr_o  output  32  registered instruction to decode
valid_o  output  1  instr_o holds a live (non-squashed) instruction
pc_write_o  output  1  PC update enable to fetch (combinational)
bubble_o  output  1  decode must force all WB/M/EX controls into ID/EX to 0 (combinational)
stall_cnt_o  output  CNT_W  count of stall cycles, saturating
flush_cnt_o  output  CNT_W  count of flush cycles, saturating

Behaviour:
- Reset (rst_i=0, asynchronous): pc_o=0, instr_o=0, valid_o=0, stall_cnt_o=0, flush_cnt_o=0. Reset asserted mid-stall or mid-flush clears everything immediately. The first edge after release behaves as a normal load.
- Field decode on the registered instruction: rs=instr_o[25:21], rt=instr_o[20:16], op=instr_o[31:26].
- uses_rt=1 when op is 6'b000000 (R-type), 6'b000100 (beq) or 6'b101011 (sw). uses_rt=0 otherwise.
- hazard (combinational) = valid_o & idex_memread_i & (idex_rt_i != 0) & ((idex_rt_i == rs) | (uses_rt & idex_rt_i == rt)).
- stall = hazard & ~flush_i. Flush has priority over stall.
- pc_write_o = ~stall. bubble_o = stall.
- Rising edge, priority order:
  1. flush_i=1: instr_o <= 0 (nop), valid_o <= 0, pc_o <= pc_i, flush_cnt_o increments.
  2. stall=1: pc_o, instr_o and valid_o hold; stall_cnt_o increments.
  3. Otherwise: pc_o <= pc_i, instr_o <= instr_i, valid_o <= 1.
- Latency: one cycle from inputs to outputs on a normal load.
- A stall lasts exactly one cycle. On the next edge ID/EX holds the bubble (memread=0), so the hazard deasserts by construction.
- Counters saturate at all-ones and never wrap. A simultaneous flush_i and hazard counts as a flush only.
- No hazard can be raised while valid_o=0. A squashed nop never stalls.
- Register $0: idex_rt_i=0 never raises a hazard, even if rs or rt is 0.

Test Plan:
- Reset: hold rst_i=0 with random inputs -> all outputs 0, pc_write_o=1, bubble_o=0. Release, pc_i=0x4, instr_i=0x00221820 -> next edge pc_o=0x4, instr_o=0x00221820, valid_o=1.
- Load-use: instr_o=add $3,$1,$2 (0x00221820) valid, idex_memread_i=1, idex_rt_i=1 -> pc_write_o=0, bubble_o=1, outputs hold for one edge, stall_cnt_o=1. Next cycle idex_memread_i=0 -> normal load resumes.
- rt ignored for I-type: instr_o=addi $5,$2,7 (0x20450007), idex_memread_i=1, idex_rt_i=5 -> no stall. Same case with idex_rt_i=2 -> stall.
- Flush beats stall: hazard active plus flush_i=1 -> instr_o=0, valid_o=0, pc_write_o=1, flush_cnt_o+1, stall_cnt_o unchanged.
- $0 and invalid: idex_rt_i=0 with rs=0 -> no stall. valid_o=0 with a matching rt -> no stall.
- Saturation and async reset: force repeated stalls until stall_cnt_o reaches 0xFFFF, one more stall -> stays 0xFFFF. Pulse rst_i low between clock edges -> counters clear immediately.
